// File: rtl/alu_operand_stage.sv
// Decode-to-execute boundary: ALU operand/function selection feeding a 2-entry skid buffer.
// The head entry drives the ALU inputs directly; in_ready depends only on flops.
package alu_operand_stage_pkg;
  localparam int unsigned FUN_W  = 10;
  localparam int unsigned TYPE_W = 6;

  // One-hot instruction type bit positions, {J,I,U,B,S,R}
  localparam int unsigned T_R = 0;
  localparam int unsigned T_S = 1;
  localparam int unsigned T_B = 2;
  localparam int unsigned T_U = 3;
  localparam int unsigned T_I = 4;
  localparam int unsigned T_J = 5;

  localparam logic [FUN_W-1:0] FUN_SUB = 10'h020;

  // Buffer occupancy encoded as {head_valid, skid_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } buf_state_e;
endpackage

module alu_operand_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_fun,
  input  logic [5:0]       in_type,
  input  logic             in_auipc,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       alu_fun,
  output logic [5:0]       alu_type,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [WIDTH-1:0] out_pc,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [alu_operand_stage_pkg::FUN_W-1:0]  fun;
    logic [alu_operand_stage_pkg::TYPE_W-1:0] typ;
    logic [WIDTH-1:0]                         in1;
    logic [WIDTH-1:0]                         in2;
    logic [WIDTH-1:0]                         pc;
    logic [TAG_W-1:0]                         tag;
  } entry_t;

  alu_operand_stage_pkg::buf_state_e state_q, state_d;
  entry_t head_q, skid_q, sel;
  logic   push, pop;
  logic   load_head_in, load_head_skid, load_skid;

  // Operand and function canonicalisation; malformed types collapse to add 0+0
  always_comb begin
    sel     = '0;
    sel.pc  = in_pc;
    sel.tag = in_tag;
    if ($onehot(in_type)) begin
      sel.typ = in_type;
      if (in_type[alu_operand_stage_pkg::T_R]) begin
        sel.fun = in_fun;
        sel.in1 = in_rs1;
        sel.in2 = in_rs2;
      end else if (in_type[alu_operand_stage_pkg::T_I]) begin
        sel.fun = {in_fun[9:7], 7'h00};
        sel.in1 = in_rs1;
        sel.in2 = in_imm;
      end else if (in_type[alu_operand_stage_pkg::T_S]) begin
        sel.in1 = in_rs1;
        sel.in2 = in_imm;
      end else if (in_type[alu_operand_stage_pkg::T_B]) begin
        sel.fun = alu_operand_stage_pkg::FUN_SUB;
        sel.in1 = in_rs1;
        sel.in2 = in_rs2;
      end else if (in_type[alu_operand_stage_pkg::T_U]) begin
        sel.in1 = in_auipc ? in_pc : '0;
        sel.in2 = in_imm;
      end else begin
        sel.in1 = in_pc;
        sel.in2 = in_imm;
      end
    end
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Buffer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= alu_operand_stage_pkg::EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and buffer load controls
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      alu_operand_stage_pkg::EMPTY: begin
        if (push) begin
          load_head_in = 1'b1;
          state_d      = alu_operand_stage_pkg::ONE;
        end
      end
      alu_operand_stage_pkg::ONE: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_d   = alu_operand_stage_pkg::FULL;
        end else if (pop) begin
          state_d = alu_operand_stage_pkg::EMPTY;
        end
      end
      alu_operand_stage_pkg::FULL: begin
        if (pop) begin
          load_head_skid = 1'b1;
          state_d        = alu_operand_stage_pkg::ONE;
        end
      end
      default: state_d = alu_operand_stage_pkg::EMPTY;
    endcase
    if (flush) begin
      state_d        = alu_operand_stage_pkg::EMPTY;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Entry storage; contents only cleared by reset, validity lives in state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head_in) begin
        head_q <= sel;
      end else if (load_head_skid) begin
        head_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= sel;
      end
    end
  end

  assign out_valid = state_q[1];
  assign in_ready  = ~state_q[0];
  assign alu_fun   = head_q.fun;
  assign alu_type  = head_q.typ;
  assign alu_in1   = head_q.in1;
  assign alu_in2   = head_q.in2;
  assign out_pc    = head_q.pc;
  assign out_tag   = head_q.tag;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and randomised checks of alu_operand_stage against hand-computed vectors and a FIFO model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_fun;
  logic [5:0]  in_type;
  logic        in_auipc;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  alu_fun;
  logic [5:0]  alu_type;
  logic [31:0] alu_in1, alu_in2, out_pc;
  logic [4:0]  out_tag;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0]  fun;
    logic [5:0]  typ;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] pc;
    logic [4:0]  tag;
  } ent_t;

  ent_t q[$];

  alu_operand_stage #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fun(in_fun), .in_type(in_type), .in_auipc(in_auipc),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_fun(alu_fun), .alu_type(alu_type), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .out_pc(out_pc), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [9:0] f, input logic [5:0] t, input logic au,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] tag);
    in_fun = f; in_type = t; in_auipc = au; in_pc = pc;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_tag = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();
  endtask

  // Reference selection written from the instruction-type table
  function automatic ent_t model(input logic [9:0] f, input logic [5:0] t, input logic au,
                                 input logic [31:0] pc, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [31:0] imm,
                                 input logic [4:0] tag);
    ent_t e;
    e = '0; e.pc = pc; e.tag = tag;
    case (t)
      6'h01: begin e.typ = t; e.fun = f;                 e.in1 = rs1; e.in2 = rs2; end
      6'h02: begin e.typ = t;                            e.in1 = rs1; e.in2 = imm; end
      6'h04: begin e.typ = t; e.fun = 10'h020;           e.in1 = rs1; e.in2 = rs2; end
      6'h08: begin e.typ = t; e.in1 = au ? pc : 32'h0;   e.in2 = imm; end
      6'h10: begin e.typ = t; e.fun = {f[9:7], 7'h00};   e.in1 = rs1; e.in2 = imm; end
      6'h20: begin e.typ = t;                            e.in1 = pc;  e.in2 = imm; end
      default: e.typ = 6'h00;
    endcase
    return e;
  endfunction

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({alu_fun, alu_type} !== 16'h0) begin errors++; $display("FAIL reset_fun_type got %h exp 0", {alu_fun, alu_type}); end
    checks++; if ({alu_in1, alu_in2, out_pc, out_tag} !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", {alu_in1, alu_in2, out_pc, out_tag}); end
  endtask

  task automatic test_r_add();
    out_ready = 1'b1;
    drive(10'h000, 6'h01, 1'b0, 32'h40, 32'd5, 32'd7, 32'h99, 5'd3);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL radd_valid got %b exp 1", out_valid); end
    checks++; if (alu_in1 !== 32'd5) begin errors++; $display("FAIL radd_in1 got %h exp 5", alu_in1); end
    checks++; if (alu_in2 !== 32'd7) begin errors++; $display("FAIL radd_in2 got %h exp 7", alu_in2); end
    checks++; if ({alu_fun, alu_type} !== {10'h000, 6'h01}) begin errors++; $display("FAIL radd_fun_type got %h exp 0001", {alu_fun, alu_type}); end
    checks++; if ({out_pc, out_tag} !== {32'h40, 5'd3}) begin errors++; $display("FAIL radd_pc_tag got %h/%h exp 40/3", out_pc, out_tag); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL radd_popped got %b exp 0", out_valid); end
  endtask

  task automatic test_i_srai();
    out_ready = 1'b1;
    drive({3'h5, 7'h20}, 6'h10, 1'b0, 32'h44, 32'h8000_0000, 32'hdead, 32'h404, 5'd4);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (alu_fun !== 10'h280) begin errors++; $display("FAIL srai_fun got %h exp 280", alu_fun); end
    checks++; if (alu_in1 !== 32'h8000_0000) begin errors++; $display("FAIL srai_in1 got %h exp 80000000", alu_in1); end
    checks++; if (alu_in2 !== 32'h404) begin errors++; $display("FAIL srai_in2 got %h exp 404", alu_in2); end
    drain();
  endtask

  task automatic test_u_b_invalid();
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive(10'h3ff, 6'h08, 1'b1, 32'h1000, 32'h11, 32'h22, 32'h20000, 5'd5);
    step();
    checks++; if ({alu_in1, alu_in2} !== {32'h1000, 32'h20000}) begin errors++; $display("FAIL auipc_ops got %h %h exp 1000 20000", alu_in1, alu_in2); end
    checks++; if (alu_fun !== 10'h000) begin errors++; $display("FAIL auipc_fun got %h exp 0", alu_fun); end
    drive(10'h3ff, 6'h08, 1'b0, 32'h1000, 32'h11, 32'h22, 32'h20000, 5'd6);
    step();
    checks++; if ({alu_in1, alu_in2, out_tag} !== {32'h0, 32'h20000, 5'd6}) begin errors++; $display("FAIL lui_ops got %h %h tag %h exp 0 20000 6", alu_in1, alu_in2, out_tag); end
    drive(10'h155, 6'h04, 1'b0, 32'h1004, 32'd9, 32'd3, 32'h77, 5'd7);
    step();
    checks++; if ({alu_fun, alu_in1, alu_in2} !== {10'h020, 32'd9, 32'd3}) begin errors++; $display("FAIL branch got %h %h %h exp 020 9 3", alu_fun, alu_in1, alu_in2); end
    drive(10'h155, 6'h03, 1'b1, 32'h1008, 32'h5, 32'h6, 32'h7, 5'd8);
    step();
    checks++; if ({alu_fun, alu_type, alu_in1, alu_in2} !== '0) begin errors++; $display("FAIL bad_type got %h %h %h %h exp 0", alu_fun, alu_type, alu_in1, alu_in2); end
    checks++; if ({out_valid, out_tag} !== {1'b1, 5'd8}) begin errors++; $display("FAIL bad_type_valid got %b %h exp 1 8", out_valid, out_tag); end
    drive(10'h155, 6'h20, 1'b0, 32'h100c, 32'h5, 32'h6, 32'h30, 5'd9);
    step();
    in_valid = 1'b0;
    checks++; if ({alu_in1, alu_in2, alu_type} !== {32'h100c, 32'h30, 6'h20}) begin errors++; $display("FAIL jal got %h %h %h exp 100c 30 20", alu_in1, alu_in2, alu_type); end
    drain();
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int rcvd = 0;
    logic fire_in, fire_out;
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(10'h0, 6'h01, 1'b0, 32'h2000, 32'h0, 32'h0, 32'h0, 5'd0);
    step();
    sent = 1;
    drive(10'h0, 6'h01, 1'b0, 32'h2004, 32'h1, 32'h1, 32'h0, 5'd1);
    step();
    sent = 2;
    drive(10'h0, 6'h01, 1'b0, 32'h2008, 32'h2, 32'h2, 32'h0, 5'd2);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    repeat (3) step();
    checks++; if ({out_valid, out_tag, alu_in1} !== {1'b1, 5'd0, 32'h0}) begin errors++; $display("FAIL bp_stable got %b %h %h exp 1 0 0", out_valid, out_tag, alu_in1); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && rcvd < 4; cyc++) begin
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      if (fire_out) begin
        checks++;
        if (out_tag !== 5'(rcvd) || out_pc !== 32'h2000 + 32'(rcvd * 4)) begin
          errors++; $display("FAIL bp_order got tag %0d pc %h exp tag %0d", out_tag, out_pc, rcvd);
        end
        rcvd++;
      end
      if (fire_in) sent++;
      step();
      if (sent < 4) begin
        drive(10'h0, 6'h01, 1'b0, 32'h2000 + 32'(sent * 4), 32'(sent), 32'(sent), 32'h0, 5'(sent));
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++; if (rcvd != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", rcvd); end
    drain();
  endtask

  task automatic test_flush();
    int leaked = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(10'h0, 6'h01, 1'b0, 32'h3000, 32'h1, 32'h1, 32'h0, 5'd10);
    step();
    drive(10'h0, 6'h01, 1'b0, 32'h3004, 32'h2, 32'h2, 32'h0, 5'd11);
    step();
    flush = 1'b1;
    drive(10'h0, 6'h01, 1'b0, 32'h3008, 32'h3, 32'h3, 32'h0, 5'd12);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_full_ready got %b exp 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      if (out_valid) leaked++;
      step();
    end
    checks++; if (leaked != 0) begin errors++; $display("FAIL flush_leak got %0d exp 0", leaked); end
    // Flush in ONE while a push and pop are both offered
    in_valid = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_valid got %b exp 0", out_valid); end
    drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(10'h3ff, 6'h01, 1'b0, 32'h4000, 32'haaaa, 32'hbbbb, 32'h0, 5'd13);
    step();
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL areset_flags got %b%b exp 01", out_valid, in_ready); end
    checks++; if ({alu_fun, alu_type, alu_in1, alu_in2} !== '0) begin errors++; $display("FAIL areset_data got %h %h %h %h exp 0", alu_fun, alu_type, alu_in1, alu_in2); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_release got %b exp 0", out_valid); end
  endtask

  task automatic test_random();
    logic [5:0] types [8];
    ent_t exp_e;
    logic exp_push, exp_pop;
    types = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h00, 6'h21};
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        errors++; $display("FAIL rand_flags cyc %0d got v%b r%b exp occupancy %0d", cyc, out_valid, in_ready, q.size());
      end
      if (q.size() > 0) begin
        checks++;
        if ({alu_fun, alu_type, alu_in1, alu_in2, out_pc, out_tag} !== q[0]) begin
          errors++; $display("FAIL rand_head cyc %0d got %h exp %h", cyc,
                             {alu_fun, alu_type, alu_in1, alu_in2, out_pc, out_tag}, q[0]);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      drive(10'($urandom), types[$urandom_range(0, 7)], 1'($urandom), $urandom, $urandom,
            $urandom, $urandom, 5'($urandom));
      exp_e    = model(in_fun, in_type, in_auipc, in_pc, in_rs1, in_rs2, in_imm, in_tag);
      exp_push = in_valid && (q.size() < 2);
      exp_pop  = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (exp_pop) void'(q.pop_front());
        if (exp_push) q.push_back(exp_e);
      end
      step();
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(10'h0, 6'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0);
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_r_add();
    test_i_srai();
    test_u_b_invalid();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
